// File: rtl/flag_save_restore.sv
// Saves the CPU flags onto a small LIFO on interrupt entry and writes them back on return.
// Optionally clears selected flags after a push. Nested interrupts are supported up to DEPTH levels.
`timescale 1ns/1ps
module flag_save_restore #(
   parameter int         DEPTH         = 4,
   parameter int         PTR_W         = 2,
   parameter logic [4:0] PUSH_CLR_MASK = 5'b10000
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             D0,
   input  logic             CF,
   input  logic             OF,
   input  logic             NF,
   input  logic             ZF,
   input  logic             PUSH,
   input  logic             POP,
   input  logic             ERR_CLR,
   output logic [4:0]       Flags,
   output logic [4:0]       FWE,
   output logic             BUSY,
   output logic             EMPTY,
   output logic             FULL,
   output logic [PTR_W:0]   LEVEL,
   output logic             ERR
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PUSH_CLR = 2'd1,
      S_POP_WR   = 2'd2
   } state_t;

   localparam logic [PTR_W:0] ONE     = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

   state_t             state_q, state_d;
   logic [PTR_W:0]     sp_q, sp_d;
   logic [4:0]         flags_q, flags_d;
   logic [4:0]         fwe_q, fwe_d;
   logic               busy_q, busy_d;
   logic               empty_q, empty_d;
   logic               full_q, full_d;
   logic               err_q, err_d;
   logic               push_we;
   logic               new_err;
   logic [4:0]         flags_in;
   logic [PTR_W-1:0]   wr_idx;
   logic [PTR_W-1:0]   rd_idx;
   logic [4:0]         stack_q [DEPTH];

   assign flags_in = {D0, CF, OF, NF, ZF};
   assign wr_idx   = sp_q[PTR_W-1:0];
   assign rd_idx   = sp_q[PTR_W-1:0] - {{(PTR_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d = state_q;
      sp_d    = sp_q;
      flags_d = 5'b00000;
      fwe_d   = 5'b00000;
      busy_d  = 1'b0;
      push_we = 1'b0;
      new_err = 1'b0;
      case (state_q)
         S_IDLE: begin
            // PUSH wins over a simultaneous POP; the POP is dropped silently
            if (PUSH) begin
               if (full_q) begin
                  new_err = 1'b1;
               end else begin
                  push_we = 1'b1;
                  sp_d    = sp_q + ONE;
                  if (PUSH_CLR_MASK != 5'b00000) begin
                     state_d = S_PUSH_CLR;
                     fwe_d   = PUSH_CLR_MASK;
                     busy_d  = 1'b1;
                  end
               end
            end else if (POP) begin
               if (empty_q) begin
                  new_err = 1'b1;
               end else begin
                  sp_d    = sp_q - ONE;
                  flags_d = stack_q[rd_idx];
                  fwe_d   = 5'b11111;
                  busy_d  = 1'b1;
                  state_d = S_POP_WR;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            if (PUSH || POP) new_err = 1'b1;
         end
      endcase
      empty_d = (sp_d == '0);
      full_d  = (sp_d == DEPTH_L);
      // a fresh error in the same cycle as ERR_CLR keeps ERR set
      err_d   = new_err | (err_q & ~ERR_CLR);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         sp_q    <= '0;
         flags_q <= 5'b00000;
         fwe_q   <= 5'b00000;
         busy_q  <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         flags_q <= flags_d;
         fwe_q   <= fwe_d;
         busy_q  <= busy_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         err_q   <= err_d;
      end
   end

   // stack contents carry no reset; they are meaningless once SP is cleared
   always_ff @(posedge CLK) begin
      if (push_we) stack_q[wr_idx] <= flags_in;
   end

   assign Flags = flags_q;
   assign FWE   = fwe_q;
   assign BUSY  = busy_q;
   assign EMPTY = empty_q;
   assign FULL  = full_q;
   assign LEVEL = sp_q;
   assign ERR   = err_q;

endmodule

// File: doc/flag_save_restore.md
Name: flag_save_restore

Overview:
- Writer-side companion to the CPU flag register.
- On interrupt entry, it samples the current flag outputs (D0, CF, OF, NF, ZF) and pushes them onto a small LIFO. It can also clear selected flags through the flag register's write port.
- On interrupt return, it pops the saved value and writes all five flags back through the Flags/FWE bus.
- It sits between the interrupt/sequencer control and the flag register, and supports nested interrupts up to DEPTH levels.

Parameters:
- DEPTH, 4, number of saved flag sets; power of two, ≥ 2.
- PTR_W, 2, log2(DEPTH).
- PUSH_CLR_MASK, 5'b10000, per-flag mask cleared after a push, in bit order {D0,CF,OF,NF,ZF}. 0 disables the clear cycle.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- D0  input  1  current D flag from the flag register.
- CF  input  1  current carry flag.
- OF  input  1  current overflow flag.
- NF  input  1  current negative flag.
- ZF  input  1  current zero flag.
- PUSH  input  1  save request; single-cycle pulse.
- POP  input  1  restore request; single-cycle pulse.
- ERR_CLR  input  1  clears the sticky ERR.
- Flags  output  5  flag write data {D0,CF,OF,NF,ZF} = bits [4:0].
- FWE  output  5  per-flag write enable, same bit order.
- BUSY  output  1  a write-back cycle is in progress.
- EMPTY  output  1  stack holds no entries.
- FULL  output  1  stack holds DEPTH entries.
- LEVEL  output  PTR_W+1  current number of entries.
- ERR  output  1  sticky protocol error.

Behaviour:
- All outputs are registered. States are IDLE, PUSH_CLR and POP_WR.
- Reset (RESET=0, async, may occur at any time including mid-write-back):
  - state=IDLE, SP=0, Flags=0, FWE=0, BUSY=0, ERR=0, EMPTY=1, FULL=0, LEVEL=0.
  - A write-back in progress is aborted and FWE drops to 0 immediately.
  - Stack contents are don't-care after reset.
- IDLE, PUSH=1, not FULL, sampled at edge k:
  - stack[SP] <= {D0,CF,OF,NF,ZF} as sampled at edge k; SP <= SP+1.
  - If PUSH_CLR_MASK≠0: state → PUSH_CLR.
  - If PUSH_CLR_MASK=0: stay in IDLE.
- PUSH_CLR, one cycle (k to k+1):
  - Flags=5'b00000, FWE=PUSH_CLR_MASK, BUSY=1.
  - The flag register loads at edge k+1; state → IDLE.
- IDLE, POP=1, not EMPTY, sampled at edge k:
  - SP <= SP-1; Flags <= stack[SP-1]; state → POP_WR.
- POP_WR, one cycle:
  - FWE=5'b11111, BUSY=1; state → IDLE.
- Flags and FWE are 0 in every IDLE cycle.
- Latency: request to flag-register update is 2 edges. BUSY is high for exactly 1 cycle per accepted operation.
- Simultaneous PUSH and POP in IDLE: PUSH is serviced; POP is dropped with no error.
- PUSH while FULL: no stack write, no SP change, no write-back; ERR <= 1.
- POP while EMPTY: no change, no write-back; ERR <= 1.
- PUSH or POP while BUSY=1: ignored, state unaffected; ERR <= 1.
- ERR clearing:
  - ERR clears only on reset or when ERR_CLR=1 at an edge.
  - If ERR_CLR and a new error occur in the same cycle, ERR stays 1.
- LEVEL, EMPTY and FULL update on the same edge as SP. EMPTY=(LEVEL==0), FULL=(LEVEL==DEPTH).
- SP never wraps: overflow and underflow are blocked as described above.

Test Plan:
- Reset, then flags={D0=1,CF=1,OF=0,NF=1,ZF=0}, PUSH pulse. Required response:
  - LEVEL=1 after edge 1.
  - Next cycle Flags=00000, FWE=10000, BUSY=1.
  - Then IDLE with FWE=0.
- Flags changed to 00101, then POP. Required response:
  - Next cycle Flags=11010, FWE=11111, BUSY=1.
  - LEVEL=0, EMPTY=1.
- Nested sequence: four PUSHes with flag values 00001, 00010, 00100, 01000, waiting out BUSY between each.
  - FULL=1 after the fourth.
  - A fifth PUSH gives ERR=1 and LEVEL stays 4.
  - Four POPs return 01000, 00100, 00010, 00001 in that order.
- POP on EMPTY → ERR=1, FWE stays 0. ERR_CLR pulse → ERR=0.
- PUSH and POP in the same cycle with LEVEL=1 → LEVEL=2, PUSH_CLR cycle follows, ERR=0.
- PUSH accepted, then RESET asserted during the PUSH_CLR cycle → FWE=0 and BUSY=0 immediately; LEVEL=0 and EMPTY=1 after release.
